// File: rtl/cfa_pkg.sv
// Shared constants and types for the CFA window front end.
package cfa_pkg;

    localparam int PIX_W  = 12;
    localparam int WIN    = 5;
    localparam int LB_CNT = 4;

    typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/cfa_line_buf.sv
// Four cascaded line buffers sharing one column address; each accepted pixel
// reads the old column contents and pushes the new pixel into bank 0.
module cfa_line_buf #(
    parameter int DEPTH = 64,
    parameter int PIX_W = 12,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                                    clk,
    input  logic                                    we,
    input  logic [AW-1:0]                           addr,
    input  logic [PIX_W-1:0]                        din,
    output logic [cfa_pkg::LB_CNT-1:0][PIX_W-1:0]   rd
);
    import cfa_pkg::*;

    logic [PIX_W-1:0] mem [LB_CNT][DEPTH];

    // Bank k holds the line that is k+1 lines older than the current one.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[0][addr] <= din;
            for (int unsigned k = 1; k < LB_CNT; k++) begin
                mem[k][addr] <= mem[k-1][addr];
            end
        end
    end

    always_comb begin
        rd = '0;
        for (int unsigned k = 0; k < LB_CNT; k++) begin
            rd[k] = mem[k][addr];
        end
    end

endmodule

// File: rtl/cfa_window_gen.sv
// Raster-to-5x5 window generator: line buffers plus a shifting tap array,
// raising start for every window whose trigger pixel is at row>=4, col>=4.
module cfa_window_gen #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 48,
    parameter int PIX_W = cfa_pkg::PIX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic [PIX_W-1:0] e1t1, e1t2, e1t3, e1t4, e1t5,
    output logic [PIX_W-1:0] e2t1, e2t2, e2t3, e2t4, e2t5,
    output logic [PIX_W-1:0] e3t1, e3t2, e3t3, e3t4, e3t5,
    output logic [PIX_W-1:0] e4t1, e4t2, e4t3, e4t4, e4t5,
    output logic [PIX_W-1:0] e5t1, e5t2, e5t3, e5t4, e5t5,
    output logic             start,
    output logic             frame_done
);
    import cfa_pkg::*;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]                  col, a_col;
    logic [RW-1:0]                  row, a_row;
    logic [PIX_W-1:0]               win [WIN][WIN];
    logic [LB_CNT-1:0][PIX_W-1:0]   lb_rd;
    logic                           lb_we;

    // sof overrides the counters so the pixel is treated as (0,0).
    assign a_col = sof ? '0 : col;
    assign a_row = sof ? '0 : row;
    assign lb_we = pix_valid & ~rst;

    cfa_line_buf #(
        .DEPTH (IMG_W),
        .PIX_W (PIX_W)
    ) u_line_buf (
        .clk  (clk),
        .we   (lb_we),
        .addr (a_col),
        .din  (pix_in),
        .rd   (lb_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < WIN; r++) begin
                for (int unsigned c = 0; c < WIN; c++) begin
                    win[r][c] <= '0;
                end
            end
            start      <= 1'b0;
            frame_done <= 1'b0;
            col        <= '0;
            row        <= '0;
        end else begin
            start      <= 1'b0;
            frame_done <= 1'b0;
            if (pix_valid) begin
                for (int unsigned r = 0; r < WIN; r++) begin
                    for (int unsigned c = 0; c < WIN - 1; c++) begin
                        win[r][c] <= win[r][c+1];
                    end
                end
                // Oldest bank feeds the top tap row; the live pixel feeds the bottom.
                for (int unsigned r = 0; r < LB_CNT; r++) begin
                    win[r][WIN-1] <= lb_rd[LB_CNT-1-r];
                end
                win[WIN-1][WIN-1] <= pix_in;
                start      <= (a_row >= RW'(WIN - 1)) && (a_col >= CW'(WIN - 1));
                frame_done <= (a_row == RW'(IMG_H - 1)) && (a_col == CW'(IMG_W - 1));
                if (a_col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (a_row == RW'(IMG_H - 1)) ? '0 : a_row + 1'b1;
                end else begin
                    col <= a_col + 1'b1;
                    row <= a_row;
                end
            end
        end
    end

    assign e1t1 = win[0][0]; assign e1t2 = win[0][1]; assign e1t3 = win[0][2]; assign e1t4 = win[0][3]; assign e1t5 = win[0][4];
    assign e2t1 = win[1][0]; assign e2t2 = win[1][1]; assign e2t3 = win[1][2]; assign e2t4 = win[1][3]; assign e2t5 = win[1][4];
    assign e3t1 = win[2][0]; assign e3t2 = win[2][1]; assign e3t3 = win[2][2]; assign e3t4 = win[2][3]; assign e3t5 = win[2][4];
    assign e4t1 = win[3][0]; assign e4t2 = win[3][1]; assign e4t3 = win[3][2]; assign e4t4 = win[3][3]; assign e4t5 = win[3][4];
    assign e5t1 = win[4][0]; assign e5t2 = win[4][1]; assign e5t3 = win[4][2]; assign e5t4 = win[4][3]; assign e5t5 = win[4][4];

endmodule
